// File: rtl/match_controller.sv
// Purpose: pong match sequencer. It owns the match state, both scores and the serve
//   direction, gates motion through run_o and requests a ball re-centre through serve_o.
// Latency: every output is registered and changes on the same edge as the state change
//   (one cycle after the causing input). There is no backpressure: inputs are sampled
//   every cycle and nothing is stalled.
// Optional feature: MATCH_PAUSE_EN (define to enable the pause key / PAUSED state).
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   frame_i          one-cycle pulse per frame; advances SERVE/POINT timers
//   start_i/pause_i  key levels; rising edges detected internally
//   miss_left_i      player scores; miss_right_i: pc scores (PLAY only)
//   rnd_bit_i        first serve direction, latched when leaving IDLE
//   run_o            motion enable; serve_o: one-cycle re-centre pulse
//   serve_dir_o      1 = toward player; score_player_o / score_pc_o: scores
//   game_over_o      high in OVER; winner_o: 1 = player won; state_o: encoded state
module match_controller #(
  parameter int SCORE_W      = 4,
  parameter int WIN_SCORE    = 9,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90,
  parameter int CNT_W        = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               frame_i,
  input  logic               start_i,
  input  logic               pause_i,
  input  logic               miss_left_i,
  input  logic               miss_right_i,
  input  logic               rnd_bit_i,
  output logic               run_o,
  output logic               serve_o,
  output logic               serve_dir_o,
  output logic [SCORE_W-1:0] score_player_o,
  output logic [SCORE_W-1:0] score_pc_o,
  output logic               game_over_o,
  output logic               winner_o,
  output logic [2:0]         state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SERVE  = 3'd1,
    S_PLAY   = 3'd2,
    S_POINT  = 3'd3,
    S_OVER   = 3'd4,
    S_PAUSED = 3'd5
  } state_t;

`ifdef MATCH_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  // Pause key has no effect; PAUSED can never be entered.
  localparam bit PAUSE_EN = 1'b0;
`endif

  // Timed states exit on the frame pulse that finds the counter at N-1,
  // so each lasts exactly N frame pulses.
  localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0]   POINT_LAST = CNT_W'(POINT_FRAMES - 1);
  // Comparing the pre-increment score avoids an extra adder on the compare path.
  localparam logic [SCORE_W-1:0] WIN_M1     = SCORE_W'(WIN_SCORE - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               start_q;
  logic               pause_q;
  logic               start_edge;
  logic               pause_edge;

  assign start_edge = start_i & ~start_q;
  assign pause_edge = PAUSE_EN & pause_i & ~pause_q;
  assign state_o    = state;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= S_IDLE;
      cnt            <= '0;
      start_q        <= 1'b0;
      pause_q        <= 1'b0;
      run_o          <= 1'b0;
      serve_o        <= 1'b0;
      serve_dir_o    <= 1'b0;
      score_player_o <= '0;
      score_pc_o     <= '0;
      game_over_o    <= 1'b0;
      winner_o       <= 1'b0;
    end else begin
      start_q <= start_i;
      pause_q <= pause_i;
      serve_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_edge) begin
            serve_dir_o <= rnd_bit_i;
            state       <= S_SERVE;
            cnt         <= '0;
          end
        end
        S_SERVE: begin
          if (frame_i) begin
            if (cnt == SERVE_LAST) begin
              state   <= S_PLAY;
              cnt     <= '0;
              run_o   <= 1'b1;
              serve_o <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        S_PLAY: begin
          if (miss_left_i && miss_right_i) begin
            // Void rally: replay the point without touching score or direction.
            state <= S_POINT;
            cnt   <= '0;
            run_o <= 1'b0;
          end else if (miss_left_i) begin
            score_player_o <= score_player_o + SCORE_W'(1);
            serve_dir_o    <= 1'b0;
            cnt            <= '0;
            run_o          <= 1'b0;
            if (score_player_o == WIN_M1) begin
              state       <= S_OVER;
              game_over_o <= 1'b1;
              winner_o    <= 1'b1;
            end else begin
              state <= S_POINT;
            end
          end else if (miss_right_i) begin
            score_pc_o  <= score_pc_o + SCORE_W'(1);
            serve_dir_o <= 1'b1;
            cnt         <= '0;
            run_o       <= 1'b0;
            if (score_pc_o == WIN_M1) begin
              state       <= S_OVER;
              game_over_o <= 1'b1;
              winner_o    <= 1'b0;
            end else begin
              state <= S_POINT;
            end
          end else if (pause_edge) begin
            // Misses take priority over pause; counter is left as is.
            state <= S_PAUSED;
            run_o <= 1'b0;
          end
        end
        S_POINT: begin
          if (frame_i) begin
            if (cnt == POINT_LAST) begin
              state <= S_SERVE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        S_OVER: begin
          // Serve direction carries over from the final point.
          if (start_edge) begin
            score_player_o <= '0;
            score_pc_o     <= '0;
            state          <= S_SERVE;
            cnt            <= '0;
            game_over_o    <= 1'b0;
          end
        end
        S_PAUSED: begin
          // Resume goes straight back to PLAY; the ball is not re-served.
          if (pause_edge) begin
            state <= S_PLAY;
            run_o <= 1'b1;
          end
        end
        default: begin
          state       <= S_IDLE;
          cnt         <= '0;
          run_o       <= 1'b0;
          game_over_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_match_controller.sv
// Purpose: self-checking bench for match_controller against a behavioural model.
// Latency: model outputs are compared 1 time unit after each rising clock edge.
// Backpressure: none; one input vector is applied per clock.
module tb_match_controller;

  localparam int SW = 4;
  localparam int WS = 2;
  localparam int SF = 3;
  localparam int PF = 2;
  localparam int CW = 4;
`ifdef MATCH_PAUSE_EN
  localparam bit PAUSE_ON = 1'b1;
`else
  localparam bit PAUSE_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, frame, start, pause, miss_l, miss_r, rnd;
  logic run, serve, serve_dir, game_over, winner;
  logic [SW-1:0] sc_pl, sc_pc;
  logic [2:0] st;

  always #5 clk = ~clk;

  match_controller #(
    .SCORE_W(SW), .WIN_SCORE(WS), .SERVE_FRAMES(SF), .POINT_FRAMES(PF), .CNT_W(CW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .frame_i(frame), .start_i(start), .pause_i(pause),
    .miss_left_i(miss_l), .miss_right_i(miss_r), .rnd_bit_i(rnd),
    .run_o(run), .serve_o(serve), .serve_dir_o(serve_dir),
    .score_player_o(sc_pl), .score_pc_o(sc_pc), .game_over_o(game_over),
    .winner_o(winner), .state_o(st)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: the match as named phases with a frame budget.
  string m_phase;       // "idle","serve","play","point","over","paused"
  int    m_frames_left; // frame pulses still needed to leave serve/point
  int    m_pl, m_pc, m_dir, m_win, m_serve;
  bit    m_start_prev, m_pause_prev;

  function automatic int phase_code(input string p);
    case (p)
      "idle":   return 0;
      "serve":  return 1;
      "play":   return 2;
      "point":  return 3;
      "over":   return 4;
      default:  return 5;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = "idle"; m_frames_left = 0;
    m_pl = 0; m_pc = 0; m_dir = 0; m_win = 0; m_serve = 0;
    m_start_prev = 0; m_pause_prev = 0;
  endtask

  task automatic model_step();
    bit start_hit, pause_hit;
    if (rst) begin
      model_reset();
      return;
    end
    start_hit = start && !m_start_prev;
    pause_hit = PAUSE_ON && pause && !m_pause_prev;
    m_start_prev = start;
    m_pause_prev = pause;
    m_serve = 0;
    if (m_phase == "idle") begin
      if (start_hit) begin m_dir = rnd; m_phase = "serve"; m_frames_left = SF; end
    end else if (m_phase == "serve") begin
      if (frame) begin
        m_frames_left--;
        if (m_frames_left == 0) begin m_phase = "play"; m_serve = 1; end
      end
    end else if (m_phase == "play") begin
      if (miss_l && miss_r) begin
        m_phase = "point"; m_frames_left = PF;
      end else if (miss_l || miss_r) begin
        if (miss_l) begin m_pl++; m_dir = 0; end
        else begin m_pc++; m_dir = 1; end
        if (m_pl == WS || m_pc == WS) begin
          m_phase = "over"; m_win = (m_pl == WS);
        end else begin
          m_phase = "point"; m_frames_left = PF;
        end
      end else if (pause_hit) begin
        m_phase = "paused";
      end
    end else if (m_phase == "point") begin
      if (frame) begin
        m_frames_left--;
        if (m_frames_left == 0) begin m_phase = "serve"; m_frames_left = SF; end
      end
    end else if (m_phase == "over") begin
      if (start_hit) begin m_pl = 0; m_pc = 0; m_phase = "serve"; m_frames_left = SF; end
    end else begin
      if (pause_hit) m_phase = "play";
    end
  endtask

  task automatic compare_all();
    check("state", int'(st), phase_code(m_phase));
    check("run", int'(run), int'(m_phase == "play"));
    check("serve", int'(serve), m_serve);
    check("serve_dir", int'(serve_dir), m_dir);
    check("score_player", int'(sc_pl), m_pl);
    check("score_pc", int'(sc_pc), m_pc);
    check("game_over", int'(game_over), int'(m_phase == "over"));
    if (m_phase == "over") check("winner", int'(winner), m_win);
  endtask

  // One clock: drive, clock, advance the model, compare away from the edge.
  task automatic cyc(input bit r, input bit f, input bit s, input bit p,
                     input bit ml, input bit mr, input bit rb);
    rst = r; frame = f; start = s; pause = p; miss_l = ml; miss_r = mr; rnd = rb;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic frames(input int n, input bit s);
    for (int i = 0; i < n; i++) cyc(0, 1, s, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    rst = 1; frame = 0; start = 0; pause = 0; miss_l = 0; miss_r = 0; rnd = 0;
    // Reset state
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    check("rst_state_const", int'(st), 0);
    // Start with rnd=1, serve timing
    cyc(0, 0, 1, 0, 0, 0, 1);
    check("idle_to_serve", int'(st), 1);
    frames(2, 1);
    check("serve_not_done", int'(st), 1);
    frames(1, 1);
    check("serve_pulse", int'(serve), 1);
    check("serve_dir_player", int'(serve_dir), 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("serve_one_cycle", int'(serve), 0);
    // Player point
    cyc(0, 0, 0, 0, 1, 0, 0);
    check("pt_player", int'(sc_pl), 1);
    check("pt_state", int'(st), 3);
    frames(PF, 0);
    check("point_to_serve", int'(st), 1);
    frames(SF, 0);
    // Void rally; misses outside PLAY ignored
    cyc(0, 0, 0, 0, 1, 1, 0);
    check("void_state", int'(st), 3);
    cyc(0, 0, 0, 0, 1, 1, 0);
    frames(PF, 0);
    frames(SF, 0);
`ifdef MATCH_PAUSE_EN
    cyc(0, 0, 0, 1, 0, 0, 0);
    check("paused", int'(st), 5);
    cyc(0, 1, 0, 1, 0, 1, 0);
    check("paused_miss_ignored", int'(sc_pc), 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    check("resume_play", int'(st), 2);
    check("resume_no_serve", int'(serve), 0);
`endif
    // PC wins with two points
    cyc(0, 0, 0, 0, 0, 1, 0);
    frames(PF, 0);
    frames(SF, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    check("over_state", int'(st), 4);
    check("over_winner_pc", int'(winner), 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    check("restart_state", int'(st), 1);
    check("restart_cleared", int'(sc_pc), 0);

    // Randomized run
    for (int i = 0; i < 4000; i++) begin
      bit ns, np;
      ns = ($urandom_range(0, 9) == 0) ? ~start : start;
      np = ($urandom_range(0, 7) == 0) ? ~pause : pause;
      cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 1) == 1), ns, np,
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
